add_64: RTL and testbench
=========================

Name: add_64

Overview:
- 64-bit binary adder with carry-in and carry-out, built as a ripple-carry chain of 1-bit full adders.
- Used as the arithmetic core of the sequential processor's ALU (ADD/SUB paths, PC increment).
- Provides zero-latency combinational results and a one-cycle registered copy for the datapath pipeline/state registers.

Parameters:
- WIDTH, 64, operand and result width in bits; the design and its verification are defined for 64 only.

Ports:
- clk  in  1  system clock; all registers update on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- a  in  64  operand A, unsigned or two's complement.
- b  in  64  operand B.
- cin  in  1  carry-in to bit 0.
- in_valid  in  1  marks a, b, cin as a valid operation this cycle.
- sum  out  64  combinational result, (a + b + cin) mod 2^64.
- cout  out  1  combinational carry out of bit 63.
- sum_q  out  64  registered sum.
- cout_q  out  1  registered cout.
- ovf_q  out  1  registered signed overflow; see Optional Feature.
- out_valid  out  1  registered in_valid.

Behaviour:
- Combinational path:
  - sum and cout are pure functions of a, b, cin, with no clock dependency.
  - {cout, sum} = a + b + cin, computed at 65-bit width.
  - sum and cout settle within one clock period; there is no latency.
  - sum and cout are independent of rst and in_valid.
- Carry chain:
  - Bit i computes s[i] = a[i]^b[i]^c[i] and c[i+1] = a[i]&b[i] | a[i]&c[i] | b[i]&c[i].
  - c[0] = cin; cout = c[64].
- Registered path, latency 1 cycle:
  - On each rising edge with rst=1: sum_q=0, cout_q=0, ovf_q=0, out_valid=0.
  - Else if in_valid=1: sum_q<=sum, cout_q<=cout, ovf_q<=ovf_next, out_valid<=1.
  - Else: sum_q, cout_q and ovf_q hold their values, and out_valid<=0.
- Reset mid-operation: reset has priority. An in_valid asserted in the same cycle as rst is discarded, and out_valid is 0 on the following cycle.
- Boundaries:
  - All-ones + 1 wraps to 0 with cout=1.
  - 0 + 0 + cin=1 gives 1.
  - All-ones + all-ones + 1 gives all-ones with cout=1.
- X handling: none required. Inputs are assumed driven; the bench must not drive X.

Optional Feature:
- Macro: ADD_OVERFLOW_EN.
- Defined:
  - ovf_next = (a[63]==b[63]) && (sum[63]!=a[63]).
  - This is two's-complement signed overflow of a+b+cin.
  - ovf_q is registered as described in Behaviour.
- Undefined:
  - The ovf_q port still exists and is tied to constant 0.
  - No overflow logic is synthesized.

Decomposition:
- Package add_pkg holds:
  - localparam ADD_WIDTH = 64;
  - typedef logic [ADD_WIDTH-1:0] word_t, used for a, b, sum and sum_q.
- Sub-module full_adder (inputs a, b, cin; outputs s, cout) is instantiated 64 times via a generate loop.
- Top level holds the carry vector, the output registers and the optional overflow logic.

Test Plan:
- rst=1 for 2 cycles, then release -> sum_q=0, cout_q=0, ovf_q=0, out_valid=0.
- a=0, b=0, cin=0 -> sum=0, cout=0; with in_valid=1, next cycle sum_q=0, out_valid=1.
- a=10, b=15, cin=0 -> sum=25, cout=0; then cin=1 -> sum=26, cout=0; registered copies follow one cycle later.
- a=0xFFFFFFFFFFFFFFFF, b=1, cin=0 -> sum=0, cout=1, ovf=0.
- a=b=0x7FFFFFFFFFFFFFFF, cin=0 -> sum=0xFFFFFFFFFFFFFFFE, cout=0; ovf_q=1 with ADD_OVERFLOW_EN defined, 0 without it.
- in_valid=1 with rst=1 in the same cycle (a=5, b=6) -> next cycle out_valid=0, sum_q=0; then in_valid=0 for 3 cycles -> sum_q holds and out_valid=0.

Source files
------------

// File: rtl/add_pkg.sv
// Shared width and word type for the 64-bit adder slice.
package add_pkg;

  localparam int unsigned ADD_WIDTH = 64;

  typedef logic [ADD_WIDTH-1:0] word_t;

endpackage : add_pkg

// File: rtl/full_adder.sv
// One-bit full adder cell; the ripple chain in add_64 is built from these.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  always_comb begin
    s    = a ^ b ^ cin;
    cout = (a & b) | (a & cin) | (b & cin);
  end

endmodule : full_adder

// File: rtl/add_64.sv
// 64-bit ripple-carry adder with a combinational result and a one-cycle registered copy.
// Optional signed-overflow flag is enabled by defining ADD_OVERFLOW_EN.
module add_64
  import add_pkg::*;
#(
  parameter int unsigned WIDTH = ADD_WIDTH
) (
  input  logic  clk,
  input  logic  rst,
  input  word_t a,
  input  word_t b,
  input  logic  cin,
  input  logic  in_valid,
  output word_t sum,
  output logic  cout,
  output word_t sum_q,
  output logic  cout_q,
  output logic  ovf_q,
  output logic  out_valid
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .s    (sum[i]),
      .cout (carry[i+1])
    );
  end

  assign cout = carry[WIDTH];

  word_t sum_d;
  logic  cout_d;
  logic  valid_d;
  logic  valid_q;

  // Result registers capture only on valid operations and hold otherwise.
  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    valid_d = in_valid;
    if (in_valid) begin
      sum_d  = sum;
      cout_d = cout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      valid_q <= valid_d;
    end
  end

  assign out_valid = valid_q;

`ifdef ADD_OVERFLOW_EN
  logic ovf_next;
  logic ovf_d;

  always_comb begin
    ovf_next = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    ovf_d    = ovf_q;
    if (in_valid) begin
      ovf_d = ovf_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end
`else
  assign ovf_q = 1'b0;
`endif

endmodule : add_64

// File: tb/tb_add_64.sv
// Directed self-checking bench for add_64 with hand-computed expected values.
module tb_add_64;
  import add_pkg::*;

  logic  clk;
  logic  rst;
  word_t a;
  word_t b;
  logic  cin;
  logic  in_valid;
  word_t sum;
  logic  cout;
  word_t sum_q;
  logic  cout_q;
  logic  ovf_q;
  logic  out_valid;

  int n_checks;
  int n_fail;

`ifdef ADD_OVERFLOW_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  add_64 #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .in_valid  (in_valid),
    .sum       (sum),
    .cout      (cout),
    .sum_q     (sum_q),
    .cout_q    (cout_q),
    .ovf_q     (ovf_q),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (sum_q !== 64'h0) begin n_fail++; $display("FAIL reset_sum_q got %h expected %h", sum_q, 64'h0); end
    n_checks++;
    if ({cout_q, ovf_q, out_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got %b expected 000", {cout_q, ovf_q, out_valid});
    end
  endtask

  task automatic test_zero();
    @(negedge clk);
    a = 64'h0; b = 64'h0; cin = 1'b0; in_valid = 1'b1;
    #1;
    n_checks++;
    if ({cout, sum} !== 65'h0) begin n_fail++; $display("FAIL zero_comb got %h expected %h", {cout, sum}, 65'h0); end
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, sum_q} !== {1'b1, 64'h0}) begin
      n_fail++; $display("FAIL zero_reg got v=%b s=%h expected v=1 s=0", out_valid, sum_q);
    end
  endtask

  task automatic test_small();
    @(negedge clk);
    a = 64'd10; b = 64'd15; cin = 1'b0; in_valid = 1'b1;
    #1;
    n_checks++;
    if ({cout, sum} !== 65'd25) begin n_fail++; $display("FAIL small_comb got %0d expected 25", {cout, sum}); end
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, cout_q, sum_q} !== {1'b1, 1'b0, 64'd25}) begin
      n_fail++; $display("FAIL small_reg got v=%b c=%b s=%0d expected v=1 c=0 s=25", out_valid, cout_q, sum_q);
    end
    @(negedge clk);
    cin = 1'b1;
    #1;
    n_checks++;
    if ({cout, sum} !== 65'd26) begin n_fail++; $display("FAIL small_cin_comb got %0d expected 26", {cout, sum}); end
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, cout_q, sum_q} !== {1'b1, 1'b0, 64'd26}) begin
      n_fail++; $display("FAIL small_cin_reg got v=%b c=%b s=%0d expected v=1 c=0 s=26", out_valid, cout_q, sum_q);
    end
  endtask

  task automatic test_boundaries();
    word_t vec_a [3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    word_t vec_b [3] = '{64'h1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF};
    logic  vec_c [3] = '{1'b0, 1'b1, 1'b1};
    word_t exp_s [3] = '{64'h0, 64'h1, 64'hFFFF_FFFF_FFFF_FFFF};
    logic  exp_c [3] = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = vec_a[i]; b = vec_b[i]; cin = vec_c[i]; in_valid = 1'b1;
      #1;
      n_checks++;
      if ({cout, sum} !== {exp_c[i], exp_s[i]}) begin
        n_fail++; $display("FAIL boundary%0d_comb got c=%b s=%h expected c=%b s=%h", i, cout, sum, exp_c[i], exp_s[i]);
      end
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, ovf_q, cout_q, sum_q} !== {1'b1, 1'b0, exp_c[i], exp_s[i]}) begin
        n_fail++; $display("FAIL boundary%0d_reg got v=%b o=%b c=%b s=%h expected v=1 o=0 c=%b s=%h",
                           i, out_valid, ovf_q, cout_q, sum_q, exp_c[i], exp_s[i]);
      end
    end
  endtask

  task automatic test_overflow();
    @(negedge clk);
    a = 64'h7FFF_FFFF_FFFF_FFFF; b = 64'h7FFF_FFFF_FFFF_FFFF; cin = 1'b0; in_valid = 1'b1;
    #1;
    n_checks++;
    if ({cout, sum} !== {1'b0, 64'hFFFF_FFFF_FFFF_FFFE}) begin
      n_fail++; $display("FAIL ovf_pos_comb got c=%b s=%h expected c=0 s=fffffffffffffffe", cout, sum);
    end
    @(posedge clk); #1;
    n_checks++;
    if ({ovf_q, cout_q, sum_q} !== {OVF_ON, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE}) begin
      n_fail++; $display("FAIL ovf_pos_reg got o=%b c=%b s=%h expected o=%b c=0 s=fffffffffffffffe",
                         ovf_q, cout_q, sum_q, OVF_ON);
    end
    @(negedge clk);
    a = 64'h8000_0000_0000_0000; b = 64'h8000_0000_0000_0000;
    @(posedge clk); #1;
    n_checks++;
    if ({ovf_q, cout_q, sum_q} !== {OVF_ON, 1'b1, 64'h0}) begin
      n_fail++; $display("FAIL ovf_neg_reg got o=%b c=%b s=%h expected o=%b c=1 s=0", ovf_q, cout_q, sum_q, OVF_ON);
    end
  endtask

  task automatic test_hold();
    @(negedge clk);
    a = 64'h0123_4567_89AB_CDEF; b = 64'h1111_1111_1111_1111; cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; a = 64'hDEAD_BEEF_0000_0000; b = 64'h5;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, sum_q} !== {1'b0, 64'h1234_5678_9ABC_DF00}) begin
        n_fail++; $display("FAIL hold%0d got v=%b s=%h expected v=0 s=123456789abcdf00", i, out_valid, sum_q);
      end
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; a = 64'd5; b = 64'd6; cin = 1'b0;
    #1;
    n_checks++;
    if ({cout, sum} !== 65'd11) begin n_fail++; $display("FAIL rst_comb got %0d expected 11", {cout, sum}); end
    @(posedge clk); #1;
    n_checks++;
    if ({out_valid, ovf_q, cout_q, sum_q} !== {3'b000, 64'h0}) begin
      n_fail++; $display("FAIL rst_prio got v=%b o=%b c=%b s=%h expected all 0", out_valid, ovf_q, cout_q, sum_q);
    end
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, sum_q} !== {1'b0, 64'h0}) begin
        n_fail++; $display("FAIL rst_idle%0d got v=%b s=%h expected v=0 s=0", i, out_valid, sum_q);
      end
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_zero();
    test_small();
    test_boundaries();
    test_overflow();
    test_hold();
    test_reset_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_add_64
